// File: rtl/modn_counter_sched.sv
// Round-robin arbiter that lends one external loadable mod-N counter to R requesters,
// preloading each owner's start value and pulsing done when the counter reaches N-1.
module modn_counter_sched #(
    parameter int N     = 6,
    parameter int WIDTH = 3,
    parameter int R     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req,
    input  logic [R*WIDTH-1:0]   req_n,
    input  logic [WIDTH-1:0]     cnt_q,
    output logic                 cnt_load,
    output logic [WIDTH-1:0]     cnt_n,
    output logic [R-1:0]         gnt,
    output logic [R-1:0]         done,
    output logic                 busy
);

    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [WIDTH-1:0] TC = WIDTH'(N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    function automatic logic [WIDTH-1:0] clamp_start(input logic [WIDTH-1:0] v);
        if (v > TC) begin
            return TC;
        end
        return v;
    endfunction

    // First pending requester strictly after the last owner, wrapping modulo R.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= R; k++) begin
            int j;
            j = (int'(ptr) + k) % R;
            if (!pick_vld && req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            done     <= '0;
            cnt_load <= 1'b0;
            cnt_n    <= '0;
            busy     <= 1'b0;
            ptr      <= IDX_W'(R - 1);
            owner    <= '0;
        end else begin
            done     <= '0;
            cnt_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= LOAD;
                        owner    <= pick_idx;
                        gnt      <= R'(1) << pick_idx;
                        cnt_load <= 1'b1;
                        cnt_n    <= clamp_start(req_n[int'(pick_idx)*WIDTH +: WIDTH]);
                        busy     <= 1'b1;
                    end
                end
                LOAD, RUN: begin
                    // A dropped request abandons the interval silently; the owner still
                    // counts as served so round-robin order moves on.
                    if (!req[owner]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner;
                    end else if (state == LOAD) begin
                        state <= RUN;
                    end else if (cnt_q == TC) begin
                        state       <= DONE;
                        gnt         <= '0;
                        done[owner] <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= owner;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
